// File: rtl/garegga_cen_stall.sv
// garegga_cen_stall
// Clock-enable stall/recovery stage for the 96 MHz domain. A raw periodic
// enable strobe is forwarded to the consuming core with one cycle of latency.
// While the core is held by wait_req, strobes are withheld and counted as
// debt. Once the wait ends, the missed strobes are re-issued no closer than
// MIN_GAP cycles after the previous output pulse, so the core's average rate
// is preserved. pause freezes the core and discards any outstanding debt.
//
// Ports:
//   CLK96     in   96 MHz clock, the only clock
//   RESET96   in   synchronous active-high reset
//   cen_in    in   raw single-cycle enable strobe
//   wait_req  in   hold the consumer; strobes are withheld and counted
//   pause     in   freeze the consumer; strobes are dropped, debt cleared
//   ovf_clr   in   clear the sticky overflow flag
//   cen_out   out  registered gated/recovered enable
//   debt      out  withheld strobes not yet re-issued (saturating)
//   ovf       out  sticky: a strobe arrived while debt was saturated
module garegga_cen_stall #(
  parameter int DW      = 4,
  parameter int MIN_GAP = 4
) (
  input  logic          CLK96,
  input  logic          RESET96,
  input  logic          cen_in,
  input  logic          wait_req,
  input  logic          pause,
  input  logic          ovf_clr,
  output logic          cen_out,
  output logic [DW-1:0] debt,
  output logic          ovf
);

  // MIN_GAP is at most 15, so four bits always hold the gap count.
  localparam int           GW       = 4;
  localparam logic [DW-1:0] DEBT_MAX = '1;
  localparam logic [GW-1:0] GAP_MAX  = GW'(MIN_GAP);

  logic [GW-1:0] gap;
  logic [GW-1:0] gap_d;
  logic [DW-1:0] debt_d;
  logic          pulse_d;
  logic          ovf_d;

  always_comb begin
    pulse_d = 1'b0;
    debt_d  = debt;
    ovf_d   = ovf_clr ? 1'b0 : ovf;

    if (pause) begin
      debt_d = '0;
    end else if (wait_req) begin
      if (cen_in) begin
        if (debt != DEBT_MAX) debt_d = debt + 1'b1;
        else                  ovf_d  = 1'b1;  // set wins over ovf_clr
      end
    end else if (cen_in) begin
      pulse_d = 1'b1;
    end else if ((debt != '0) && (gap >= GAP_MAX)) begin
      pulse_d = 1'b1;
      debt_d  = debt - 1'b1;
    end

    // gap restarts at 1 in the cycle the pulse is visible on cen_out, so a
    // recovery decision at gap==MIN_GAP lands MIN_GAP cycles after that pulse.
    if (pulse_d)             gap_d = GW'(1);
    else if (gap >= GAP_MAX) gap_d = GAP_MAX;
    else                     gap_d = gap + 1'b1;
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      cen_out <= 1'b0;
      debt    <= '0;
      ovf     <= 1'b0;
      gap     <= GAP_MAX;
    end else begin
      cen_out <= pulse_d;
      debt    <= debt_d;
      ovf     <= ovf_d;
      gap     <= gap_d;
    end
  end

endmodule

// File: tb/tb_garegga_cen_stall.sv
// Randomized bench for garegga_cen_stall. A behavioural model tracks the
// outstanding debt as an integer and the cycle index of the last output
// pulse; a recovery pulse is allowed when the distance in cycles from that
// last pulse is at least MIN_GAP.
module tb_garegga_cen_stall;

  localparam int DW      = 4;
  localparam int MIN_GAP = 4;
  localparam int DMAX    = (1 << DW) - 1;
  localparam int NCYC    = 20000;

  logic          CLK96 = 1'b0;
  logic          RESET96;
  logic          cen_in;
  logic          wait_req;
  logic          pause;
  logic          ovf_clr;
  logic          cen_out;
  logic [DW-1:0] debt;
  logic          ovf;

  int n_tests = 0;
  int n_fail  = 0;

  garegga_cen_stall #(.DW(DW), .MIN_GAP(MIN_GAP)) dut (
    .CLK96   (CLK96),
    .RESET96 (RESET96),
    .cen_in  (cen_in),
    .wait_req(wait_req),
    .pause   (pause),
    .ovf_clr (ovf_clr),
    .cen_out (cen_out),
    .debt    (debt),
    .ovf     (ovf)
  );

  always #5 CLK96 = ~CLK96;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // model state
  int m_out, m_debt, m_ovf, last_out, cyc;
  // stimulus state
  int strobe_cnt, mode, mode_len;
  int n_in, n_out, n_sat, n_rec;

  task automatic model_reset();
    m_out    = 0;
    m_debt   = 0;
    m_ovf    = 0;
    last_out = -1000;
  endtask

  // Compute model outputs for cycle cyc+1 from inputs applied in cycle cyc.
  task automatic model_step();
    int nxt_out;
    nxt_out = 0;
    if (RESET96) begin
      model_reset();
      return;
    end
    if (ovf_clr) m_ovf = 0;
    if (pause) begin
      m_debt = 0;
    end else if (wait_req) begin
      if (cen_in) begin
        if (m_debt < DMAX) m_debt = m_debt + 1;
        else begin
          m_ovf = 1;
          n_sat++;
        end
      end
    end else if (cen_in) begin
      nxt_out = 1;
    end else if (m_debt > 0 && (cyc + 1) - last_out >= MIN_GAP) begin
      nxt_out = 1;
      m_debt  = m_debt - 1;
      n_rec++;
    end
    m_out = nxt_out;
    if (nxt_out == 1) last_out = cyc + 1;
  endtask

  initial begin
    RESET96  = 1'b1;
    cen_in   = 1'b0;
    wait_req = 1'b0;
    pause    = 1'b0;
    ovf_clr  = 1'b0;
    n_in = 0; n_out = 0; n_sat = 0; n_rec = 0;
    model_reset();
    cyc = 0;
    repeat (3) @(posedge CLK96);
    #1;
    chk("reset_cen_out", int'(cen_out), 0);
    chk("reset_debt",    int'(debt),    0);
    chk("reset_ovf",     int'(ovf),     0);

    strobe_cnt = 3;
    mode       = 0;
    mode_len   = 40;
    for (int i = 0; i < NCYC; i++) begin
      // choose inputs for this cycle
      if (mode_len == 0) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) begin
          mode = 0; mode_len = $urandom_range(20, 200);
        end else if (r < 85) begin
          mode = 1; mode_len = $urandom_range(10, 450);
        end else begin
          mode = 2; mode_len = $urandom_range(5, 120);
        end
      end
      mode_len--;
      wait_req = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
      pause    = (mode == 2);
      ovf_clr  = ($urandom_range(0, 49) == 0);
      RESET96  = ($urandom_range(0, 2999) == 0);
      if (strobe_cnt == 0) begin
        cen_in     = 1'b1;
        strobe_cnt = $urandom_range(2 * MIN_GAP, 30) - 1;
        n_in++;
      end else begin
        cen_in = 1'b0;
        strobe_cnt--;
      end
      model_step();

      @(posedge CLK96);
      #1;
      cyc++;
      if (cen_out) n_out++;
      chk("cen_out", int'(cen_out), m_out);
      chk("debt",    int'(debt),    m_debt);
      chk("ovf",     int'(ovf),     m_ovf);
    end

    // scenario coverage sanity: saturation and recovery must both have occurred
    n_tests++;
    if (n_sat == 0 || n_rec == 0) begin
      n_fail++;
      $display("FAIL coverage: saturations=%0d recoveries=%0d, both required nonzero", n_sat, n_rec);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
